// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads program memory, and presents one word at a time to the decoder.
// Latency is 3 cycles per instruction with 1-cycle memory; the stall input and slow memory each add cycles, and no fetch is issued while an instruction is held.
module fetch_unit #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         cnt_wr_en,
  input  logic                         add_offset,
  input  logic [PC_WIDTH-1:0]          literal_adr,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [PROGRAM_DataWidth-1:0] imem_data,
  input  logic                         imem_valid,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  output logic                         instr_valid,
  output logic [PC_WIDTH-1:0]          pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EXEC} state_t;

  state_t                         state, state_nxt;
  logic [PC_WIDTH-1:0]            fetch_pc, fetch_pc_nxt;
  logic [PROGRAM_DataWidth-1:0]   ir;
  logic                           capture, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory responses are only looked at in WAIT, so stray or post-reset data is dropped.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    capture     = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_valid) begin
          capture   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Offset and PC share a width, so a plain wrapping add is the sign-extended relative jump.
  always_comb begin
    if (!cnt_wr_en)      fetch_pc_nxt = pc + PC_WIDTH'(1);
    else if (add_offset) fetch_pc_nxt = pc + literal_adr;
    else                 fetch_pc_nxt = literal_adr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= '0;
      pc       <= '0;
      ir       <= '0;
    end else begin
      if (capture) begin
        ir <= imem_data;
        pc <= fetch_pc;
      end
      if (accept) fetch_pc <= fetch_pc_nxt;
    end
  end

  assign imem_addr   = imem_req ? fetch_pc : '0;
  assign instruction = instr_valid ? ir : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed fetch/jump/stall/latency/reset sequences against a ROM model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, cnt_wr_en, add_offset;
  logic [7:0]  literal_adr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;

  always #5 clk = ~clk;

  fetch_unit #(.PC_WIDTH(8), .PROGRAM_DataWidth(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .cnt_wr_en(cnt_wr_en),
    .add_offset(add_offset), .literal_adr(literal_adr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_valid(imem_valid), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc)
  );

  logic [15:0] rom [256];
  logic [7:0]  exp_addr_q [$];
  logic [23:0] exp_exec_q [$];
  int          total = 0;
  int          bad   = 0;

  logic        mem_en;
  int          mem_lat;
  logic        mem_valid, spur_valid;
  logic [15:0] mem_data, spur_data;
  logic [7:0]  mem_a;
  logic [23:0] e;

  assign imem_valid = mem_valid | spur_valid;
  assign imem_data  = spur_valid ? spur_data : mem_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program memory: answers each strobe mem_lat cycles later, for one cycle.
  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk);
      if (imem_req && mem_en) begin
        mem_a = imem_addr;
        repeat (mem_lat) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_data  = rom[mem_a];
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_data  = '0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a fetch or retires an instruction.
  always @(negedge clk) begin
    if (imem_req) begin
      if (exp_addr_q.size() == 0) chk("req_queue_depth", 32'(exp_addr_q.size()), 32'd1);
      else chk("fetch_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
    end
    if (instr_valid && !stall) begin
      if (exp_exec_q.size() == 0) chk("exec_queue_depth", 32'(exp_exec_q.size()), 32'd1);
      else begin
        e = exp_exec_q.pop_front();
        chk("exec_pc", 32'(pc), 32'(e[23:16]));
        chk("exec_instr", 32'(instruction), 32'(e[15:0]));
      end
    end
    if (!instr_valid) chk("nop_outside_exec", 32'(instruction), 32'd0);
  end

  // One instruction: fetch p, optionally stall, then resolve the next address.
  task automatic step(input logic [7:0] p, input int lat, input int nstall,
                      input logic cwe, input logic ao, input logic [7:0] lit,
                      input bit first, input bit spur);
    int n;
    n = 0;
    exp_addr_q.push_back(p);
    exp_exec_q.push_back({p, rom[p]});
    mem_lat = lat;
    if (spur) begin
      spur_valid = 1'b1;
      spur_data  = 16'hDEAD;
    end
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      spur_valid = 1'b0;
      n = i;
      if (instr_valid) break;
    end
    chk("fetch_latency", 32'(n), first ? 32'(2 + lat) : 32'(1 + lat));
    if (spur) begin
      spur_valid = 1'b1;
      spur_data  = 16'hBEEF;
    end
    for (int k = 0; k < nstall; k++) begin
      stall       = 1'b1;
      cnt_wr_en   = 1'b1;
      add_offset  = 1'b0;
      literal_adr = 8'h80;
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_pc", 32'(pc), 32'(p));
      chk("stall_instr", 32'(instruction), 32'(rom[p]));
    end
    stall       = 1'b0;
    cnt_wr_en   = cwe;
    add_offset  = ao;
    literal_adr = lit;
    @(posedge clk);
    #1;
    chk("req_after_accept", 32'(imem_req), 32'd1);
    cnt_wr_en   = 1'b0;
    add_offset  = 1'b0;
    literal_adr = '0;
    spur_valid  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {8'(i) ^ 8'h5A, 8'(i)};
    rom[0]     = 16'h0A20;
    rom[1]     = 16'h1340;
    rom[8'h20] = 16'h4811;
    rst_n = 1'b0; stall = 1'b0; cnt_wr_en = 1'b0; add_offset = 1'b0; literal_adr = '0;
    spur_valid = 1'b0; spur_data = '0; mem_en = 1'b1; mem_lat = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    rst_n = 1'b1;

    step(8'h00, 1, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); // sequential -> 01
    step(8'h01, 1, 0, 1'b1, 1'b0, 8'h3F, 1'b0, 1'b0); // absolute -> 3F
    step(8'h3F, 1, 0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0); // absolute -> 10
    step(8'h10, 1, 0, 1'b1, 1'b1, 8'hFC, 1'b0, 1'b0); // 10 + (-4) -> 0C
    step(8'h0C, 1, 0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0); // absolute -> FE
    step(8'hFE, 1, 0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0); // FE + 5 wraps -> 03
    step(8'h03, 1, 0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0); // absolute -> FF
    step(8'hFF, 1, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0); // FF + 1 wraps -> 00
    step(8'h00, 1, 3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); // stalled, then -> 01 not 80
    step(8'h01, 1, 0, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0); // absolute -> 20
    step(8'h20, 4, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); // slow memory, stray valids -> 21

    // Abort the fetch of 0x21 with reset while waiting on memory.
    exp_addr_q.push_back(8'h21);
    mem_en = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("wait_no_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_req", 32'(imem_req), 32'd0);
    chk("abort_addr", 32'(imem_addr), 32'd0);
    chk("abort_valid", 32'(instr_valid), 32'd0);
    chk("abort_instr", 32'(instruction), 32'd0);
    chk("abort_pc", 32'(pc), 32'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    spur_valid = 1'b1;
    spur_data  = 16'hFFFF;
    @(negedge clk);
    chk("idle_addr", 32'(imem_addr), 32'd0);
    chk("idle_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    spur_valid = 1'b0;
    mem_en     = 1'b1;
    step(8'h00, 1, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); // restart at 0, late FFFF not seen
    exp_addr_q.push_back(8'h01);
    @(negedge clk);
    #1;
    chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("exec_queue_drained", 32'(exp_exec_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
